// File: rtl/convpress_compressor_stream_if.sv
// Stream bundle for the activation compressor.
// Input channel (brick in):  i_valid, o_ready, i_data, i_last, i_base_addr
// Output channel (beat out): o_valid, i_ready, o_vals, o_offs, o_count, o_addr,
//                            o_brick_end, o_layer_end
// Signal names are seen from the compressor. The compressor connects through
// the slave modport. The surrounding logic (sigmoid stage and eDRAM writer, or
// a bench) drives the compressor's inputs through the master modport.
interface convpress_compressor_stream_if #(
  parameter int N         = 16,
  parameter int TN        = 16,
  parameter int OUT_LANES = 4,
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = $clog2(TN),
  parameter int CNT_W     = $clog2(OUT_LANES + 1)
);
  logic                       i_valid;
  logic                       o_ready;
  logic [TN*N-1:0]            i_data;
  logic                       i_last;
  logic [ADDR_W-1:0]          i_base_addr;

  logic                       o_valid;
  logic                       i_ready;
  logic [OUT_LANES*N-1:0]     o_vals;
  logic [OUT_LANES*OFF_W-1:0] o_offs;
  logic [CNT_W-1:0]           o_count;
  logic [ADDR_W-1:0]          o_addr;
  logic                       o_brick_end;
  logic                       o_layer_end;

  modport slave (
    input  i_valid, i_data, i_last, i_base_addr, i_ready,
    output o_ready, o_valid, o_vals, o_offs, o_count, o_addr, o_brick_end, o_layer_end
  );

  modport master (
    output i_valid, i_data, i_last, i_base_addr, i_ready,
    input  o_ready, o_valid, o_vals, o_offs, o_count, o_addr, o_brick_end, o_layer_end
  );
endinterface

// File: rtl/convpress_compressor_stream.sv
// Activation compressor. It accepts one brick of TN activations per transfer
// and buffers up to FIFO_DEPTH bricks. For each brick it emits the nonzero
// lanes, OUT_LANES at a time, in ascending lane order, together with their lane
// offsets. Each brick is tagged with its eDRAM word address, which is the layer
// base plus the brick index.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   bus  stream bundle (slave modport): brick input and beat output channels
//
// FSM
//   state  | meaning
//   S_IDLE | no brick held; outputs invalid; pops the FIFO head when one exists
//   S_EMIT | a brick is held; the beat is presented; on the beat that ends the
//          | brick, the next head is popped directly or the FSM drops to S_IDLE
module convpress_compressor_stream #(
  parameter int N          = 16,
  parameter int TN         = 16,
  parameter int OUT_LANES  = 4,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  convpress_compressor_stream_if.slave bus
);
  localparam int OFF_W = $clog2(TN);
  localparam int CNT_W = $clog2(OUT_LANES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_FILL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_EMIT} state_t;
  state_t state_q, state_d;

  // brick buffer
  logic [TN*N-1:0]   mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fill_q, fill_d;
  logic              ready_q;
  logic              push, pop, fifo_empty;

  // address generation
  logic [ADDR_W-1:0] base_q, index_q, brick_base, brick_addr;
  logic              layer_start_q;

  // brick currently being emitted
  logic [TN*N-1:0]   cur_data;
  logic [TN-1:0]     cur_mask;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_last;
  logic [TN-1:0]     head_nz;

  // beat selection
  logic [TN-1:0]              rem_mask;
  logic [OUT_LANES*N-1:0]     slot_vals;
  logic [OUT_LANES*OFF_W-1:0] slot_offs;
  logic [CNT_W-1:0]           slot_cnt;
  logic                       found;
  logic                       out_valid, brick_end;

  assign push       = bus.i_valid && ready_q;
  assign fifo_empty = (fill_q == '0);
  assign fill_d     = fill_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  // The first brick of a layer uses the live base input. Later bricks use the stored copy.
  assign brick_base = layer_start_q ? bus.i_base_addr : base_q;
  assign brick_addr = brick_base + index_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.i_data;
      mem_addr[wr_ptr] <= brick_addr;
      mem_last[wr_ptr] <= bus.i_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_q        <= '0;
      ready_q       <= 1'b0;
      base_q        <= '0;
      index_q       <= '0;
      layer_start_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fill_q  <= fill_d;
      // o_ready is registered from the next fill level. A pop never frees a slot for a push in the same cycle.
      ready_q <= (fill_d != FULL_FILL);
      if (push) begin
        if (layer_start_q) base_q <= bus.i_base_addr;
        if (bus.i_last) begin
          index_q       <= '0;
          layer_start_q <= 1'b1;
        end else begin
          index_q       <= index_q + ADDR_W'(1);
          layer_start_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    head_nz = '0;
    for (int k = 0; k < TN; k++) begin
      head_nz[k] = |mem_data[rd_ptr][k*N +: N];
    end
  end

  // Take the lowest OUT_LANES set bits of the mask. rem_mask is what is left after this beat.
  always_comb begin
    rem_mask  = cur_mask;
    slot_vals = '0;
    slot_offs = '0;
    slot_cnt  = '0;
    found     = 1'b0;
    for (int s = 0; s < OUT_LANES; s++) begin
      found = 1'b0;
      for (int k = 0; k < TN; k++) begin
        if (!found && rem_mask[k]) begin
          found       = 1'b1;
          rem_mask[k] = 1'b0;
          slot_vals[s*N +: N]         = cur_data[k*N +: N];
          slot_offs[s*OFF_W +: OFF_W] = OFF_W'(k);
        end
      end
      if (found) slot_cnt = slot_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.i_ready && (rem_mask == '0)) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_data <= '0;
      cur_mask <= '0;
      cur_addr <= '0;
      cur_last <= 1'b0;
    end else if (pop) begin
      cur_data <= mem_data[rd_ptr];
      cur_mask <= head_nz;
      cur_addr <= mem_addr[rd_ptr];
      cur_last <= mem_last[rd_ptr];
    end else if (state_q == S_EMIT && bus.i_ready) begin
      cur_mask <= rem_mask;
    end
  end

  assign out_valid = (state_q == S_EMIT);
  // An all-zero brick has an empty mask, so its single beat is also its final beat.
  assign brick_end = out_valid && (rem_mask == '0);

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = out_valid;
  assign bus.o_vals      = out_valid ? slot_vals : '0;
  assign bus.o_offs      = out_valid ? slot_offs : '0;
  assign bus.o_count     = out_valid ? slot_cnt  : '0;
  assign bus.o_addr      = out_valid ? cur_addr  : '0;
  assign bus.o_brick_end = brick_end;
  assign bus.o_layer_end = brick_end && cur_last;
endmodule

// File: tb/tb_convpress_compressor_stream.sv
module tb_convpress_compressor_stream;
  localparam int N = 16, TN = 16, OL = 4, AW = 16, FD = 2;
  localparam int OFF_W = 4, CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  convpress_compressor_stream_if #(.N(N), .TN(TN), .OUT_LANES(OL), .ADDR_W(AW)) bus();

  convpress_compressor_stream #(.N(N), .TN(TN), .OUT_LANES(OL), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [OL*N-1:0]     vals;
    logic [OL*OFF_W-1:0] offs;
    logic [CNT_W-1:0]    cnt;
    logic [AW-1:0]       addr;
    logic                be;
    logic                le;
    int                  cyc;
  } beat_t;

  beat_t expq[$];
  beat_t got[$];
  int checks = 0, failures = 0, cyc = 0;

  logic [AW-1:0] m_base = '0, m_index = '0;
  logic          m_ls = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: split the brick's nonzero lanes into OL-sized groups, one group per beat.
  task automatic model_accept(input logic [TN*N-1:0] d, input logic last, input logic [AW-1:0] base);
    int nzl[$];
    int nb, lane;
    beat_t b;
    logic [AW-1:0] a;
    if (m_ls) m_base = base;
    a = m_base + m_index;
    for (int k = 0; k < TN; k++) if (d[k*N +: N] != '0) nzl.push_back(k);
    nb = (nzl.size() == 0) ? 1 : (nzl.size() + OL - 1) / OL;
    for (int j = 0; j < nb; j++) begin
      b.vals = '0; b.offs = '0; b.cnt = '0; b.addr = a; b.cyc = 0;
      for (int s = 0; s < OL; s++) begin
        if (j*OL + s < nzl.size()) begin
          lane = nzl[j*OL + s];
          b.vals[s*N +: N] = d[lane*N +: N];
          b.offs[s*OFF_W +: OFF_W] = lane[OFF_W-1:0];
          b.cnt = b.cnt + 1'b1;
        end
      end
      b.be = (j == nb - 1);
      b.le = b.be && last;
      expq.push_back(b);
    end
    if (last) begin m_index = '0; m_ls = 1'b1; end
    else      begin m_index = m_index + 1'b1; m_ls = 1'b0; end
  endtask

  // Called at a falling edge. Returns the number of the rising edge that accepts the brick.
  task automatic push(input logic [TN*N-1:0] d, input logic last, input logic [AW-1:0] base, output int acc);
    int t = 0;
    bus.i_valid = 1'b1; bus.i_data = d; bus.i_last = last; bus.i_base_addr = base;
    while (!bus.o_ready && t < 50) begin @(negedge clk); t++; end
    if (bus.o_ready) begin
      model_accept(d, last, base);
      acc = cyc + 1;
      @(negedge clk);
    end else begin
      checks++; failures++; acc = -1;
      $display("FAIL push_timeout actual=o_ready_low required=o_ready_high");
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (got.size() < n && t < 200) begin @(negedge clk); t++; end
    if (got.size() < n) begin
      checks++; failures++;
      $display("FAIL wait_beats actual=%0d required=%0d", got.size(), n);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    if (expq.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", expq.size());
    end
  endtask

  // Compare process: checks every handshaken beat against the model and checks that outputs hold during stalls.
  beat_t cur, prev, e;
  logic prev_stall = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (!rst) prev_stall = 1'b0;
    else begin
      cur.vals = bus.o_vals; cur.offs = bus.o_offs; cur.cnt = bus.o_count;
      cur.addr = bus.o_addr; cur.be = bus.o_brick_end; cur.le = bus.o_layer_end;
      cur.cyc = cyc + 1;
      if (prev_stall)
        chk("hold", {bus.o_valid, cur.vals, cur.offs, cur.cnt, cur.addr, cur.be, cur.le},
                    {1'b1, prev.vals, prev.offs, prev.cnt, prev.addr, prev.be, prev.le});
      if (bus.o_valid && bus.i_ready) begin
        got.push_back(cur);
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=addr_%0h required=no_beat", cur.addr);
        end else begin
          e = expq.pop_front();
          chk("beat_count", cur.cnt, e.cnt);
          chk("beat_vals", cur.vals, e.vals);
          chk("beat_offs", cur.offs, e.offs);
          chk("beat_addr", cur.addr, e.addr);
          chk("beat_brick_end", cur.be, e.be);
          chk("beat_layer_end", cur.le, e.le);
        end
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev = cur;
    end
  end

  logic [TN*N-1:0] d_inc, d_zero, d_sparse, d_two, d_full;
  int m, acc, rise, t;

  initial begin
    rst = 1'b0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0; bus.i_base_addr = '0; bus.i_ready = 1'b1;
    d_zero = '0;
    d_inc = '0; d_full = '0;
    for (int k = 0; k < TN; k++) begin
      d_inc[k*N +: N]  = 16'(k + 1);
      d_full[k*N +: N] = 16'(16'h1000 + k);
    end
    d_sparse = '0;
    d_sparse[1*N +: N] = 16'h0007; d_sparse[5*N +: N] = 16'h8000; d_sparse[15*N +: N] = 16'h0001;
    d_two = '0;
    d_two[0*N +: N] = 16'h000A; d_two[3*N +: N] = 16'h000B;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_ready", bus.o_ready, 0);
    chk("rst_o_vals", bus.o_vals, 0);
    chk("rst_o_count", bus.o_count, 0);
    chk("rst_o_addr", bus.o_addr, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.o_ready, 1);

    // 1: dense ramp brick, four full beats
    m = got.size();
    push(d_inc, 1'b1, 16'h0100, acc);
    drain();
    chk("t1_nbeats", got.size() - m, 4);
    chk("t1_b0_vals", got[m].vals, 64'h0004_0003_0002_0001);
    chk("t1_b0_offs", got[m].offs, 16'h3210);
    chk("t1_b0_cnt", got[m].cnt, 4);
    chk("t1_b0_addr", got[m].addr, 16'h0100);
    chk("t1_b1_offs", got[m+1].offs, 16'h7654);
    chk("t1_b2_offs", got[m+2].offs, 16'hBA98);
    chk("t1_b2_end", {got[m+2].be, got[m+2].le}, 2'b00);
    chk("t1_b3_offs", got[m+3].offs, 16'hFEDC);
    chk("t1_b3_vals", got[m+3].vals, 64'h0010_000F_000E_000D);
    chk("t1_b3_end", {got[m+3].be, got[m+3].le}, 2'b11);

    // 2: all-zero brick, first brick of a new layer
    m = got.size();
    push(d_zero, 1'b0, 16'h0500, acc);
    drain();
    chk("t2_nbeats", got.size() - m, 1);
    chk("t2_cnt", got[m].cnt, 0);
    chk("t2_vals", got[m].vals, 0);
    chk("t2_end", {got[m].be, got[m].le}, 2'b10);
    chk("t2_addr", got[m].addr, 16'h0500);
    chk("t2_latency", got[m].cyc - acc, 2);

    // 3: sparse lanes 1,5,15; the layer continues, so the base input is ignored
    m = got.size();
    push(d_sparse, 1'b1, 16'h0999, acc);
    drain();
    chk("t3_nbeats", got.size() - m, 1);
    chk("t3_cnt", got[m].cnt, 3);
    chk("t3_offs", got[m].offs, 16'h0F51);
    chk("t3_vals", got[m].vals, 64'h0000_0001_8000_0007);
    chk("t3_addr", got[m].addr, 16'h0501);
    chk("t3_end", {got[m].be, got[m].le}, 2'b11);

    // 5: three-brick layer at 0x200, then a new layer at 0x300
    m = got.size();
    push(d_two, 1'b0, 16'h0200, acc);
    push(d_two, 1'b0, 16'h0777, acc);
    push(d_two, 1'b1, 16'h0777, acc);
    push(d_two, 1'b1, 16'h0300, acc);
    drain();
    chk("t5_nbeats", got.size() - m, 4);
    chk("t5_addr0", got[m].addr, 16'h0200);
    chk("t5_addr1", {got[m+1].addr, got[m+1].le}, {16'h0201, 1'b0});
    chk("t5_addr2", {got[m+2].addr, got[m+2].le}, {16'h0202, 1'b1});
    chk("t5_addr3", got[m+3].addr, 16'h0300);

    // 4: stall mid-brick while the FIFO fills
    m = got.size();
    push(d_full, 1'b0, 16'h0400, acc);
    wait_beats(m + 1);
    bus.i_ready = 1'b0;
    push(d_zero, 1'b0, 16'h0000, acc);
    push(d_sparse, 1'b1, 16'h0000, acc);
    chk("t4_ready_full", bus.o_ready, 0);
    repeat (3) @(negedge clk);
    chk("t4_ready_still_full", bus.o_ready, 0);
    bus.i_ready = 1'b1;
    rise = -1; t = 0;
    while (rise < 0 && t < 20) begin
      @(negedge clk); t++;
      if (bus.o_ready) rise = cyc;
    end
    drain();
    chk("t4_nbeats", got.size() - m, 6);
    chk("t4_b3_end", got[m+3].be, 1);
    chk("t4_ready_rise", rise, got[m+3].cyc);
    chk("t4_addr_last", got[m+5].addr, 16'h0402);

    // 6: reset during the second beat of a brick
    m = got.size();
    push(d_full, 1'b0, 16'h0600, acc);
    wait_beats(m + 1);
    rst = 1'b0;
    #1;
    chk("t6_valid_in_rst", bus.o_valid, 0);
    chk("t6_ready_in_rst", bus.o_ready, 0);
    chk("t6_count_in_rst", bus.o_count, 0);
    expq.delete();
    m_index = '0; m_ls = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", bus.o_ready, 1);
    chk("t6_valid_after", bus.o_valid, 0);
    m = got.size();
    push(d_sparse, 1'b1, 16'h0700, acc);
    drain();
    chk("t6_nbeats", got.size() - m, 1);
    chk("t6_addr", got[m].addr, 16'h0700);

    chk("expq_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
